// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } arb_state_t;

  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

  localparam int DEFAULT_ADDR_W = 16;
  localparam int DEFAULT_DATA_W = 16;

  localparam logic [15:0] IO_IN_ADDR = 16'hFC00;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - winner select; MEM_ARBITER_ROUND_ROBIN_EN enables round-robin ties
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic a_elig,
  input  logic b_elig,
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  input  logic last_owner,
`endif
  output logic grant,
  output logic grant_owner
);

  always_comb begin
    grant = a_elig | b_elig;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    // On a tie the port that was not served last wins
    if (a_elig && b_elig)
      grant_owner = (last_owner == OWNER_B) ? OWNER_A : OWNER_B;
    else
      grant_owner = b_elig ? OWNER_B : OWNER_A;
`else
    grant_owner = b_elig ? OWNER_B : OWNER_A;
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port arbiter for the single-port memory; MEM_ARBITER_ROUND_ROBIN_EN selects round-robin ties
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_ack,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_q,
  output logic              busy
);

  arb_state_t state;
  logic       owner;
  logic       a_elig;
  logic       b_elig;
  logic       grant;
  logic       grant_owner;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  logic       rr_ptr;
`endif

  // A port still showing its ack is finishing, not asking again
  assign a_elig = a_req & ~a_ack;
  assign b_elig = b_req & ~b_ack;
  assign busy   = (state != IDLE);

  mem_arb_pick u_pick (
    .a_elig      (a_elig),
    .b_elig      (b_elig),
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    .last_owner  (rr_ptr),
`endif
    .grant       (grant),
    .grant_owner (grant_owner)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= OWNER_A;
      mem_addr <= '0;
      mem_data <= '0;
      mem_we   <= 1'b0;
      a_ack    <= 1'b0;
      b_ack    <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      rr_ptr   <= OWNER_B;
`endif
    end else begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            owner <= grant_owner;
            if (grant_owner == OWNER_B) begin
              mem_addr <= b_addr;
              mem_data <= b_wdata;
              mem_we   <= b_we;
            end else begin
              mem_addr <= a_addr;
              mem_data <= a_wdata;
              mem_we   <= a_we;
            end
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            rr_ptr <= grant_owner;
`endif
            state <= ISSUE;
          end
        end
        ISSUE: begin
          mem_we <= 1'b0;
          state  <= CAPTURE;
        end
        CAPTURE: begin
          // Writes return the written word since the memory is write-through
          if (owner == OWNER_B) begin
            b_rdata <= mem_q;
            b_ack   <= 1'b1;
          end else begin
            a_rdata <= mem_q;
            a_ack   <= 1'b1;
          end
          state <= IDLE;
        end
        default: begin
          mem_we <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
